// File: rtl/arbitro_memoria_if.sv
// arbitro_memoria_if: requester, response and memory-bus signals of the unified-memory arbiter
interface arbitro_memoria_if #(
  parameter int WIDTH_A = 16,
  parameter int WIDTH_D = 16
);
  logic               req_if;
  logic [WIDTH_A-1:0] addr_if;
  logic               req_d;
  logic               we_d;
  logic [WIDTH_A-1:0] addr_d;
  logic [WIDTH_D-1:0] wdata_d;
  logic               halt;
  logic               ack_if;
  logic               ack_d;
  logic [WIDTH_D-1:0] rdata;
  logic               busy;
  logic               mem_en;
  logic               mem_we;
  logic [WIDTH_A-1:0] mem_addr;
  logic [WIDTH_D-1:0] mem_wdata;
  logic [WIDTH_D-1:0] mem_rdata;
  modport slave (
    input  req_if, addr_if, req_d, we_d, addr_d, wdata_d, halt, mem_rdata,
    output ack_if, ack_d, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output req_if, addr_if, req_d, we_d, addr_d, wdata_d, halt, mem_rdata,
    input  ack_if, ack_d, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arbitro_memoria.sv
// arbitro_memoria: round-robin fetch/data arbiter sequencing fixed-latency accesses to one shared memory
module arbitro_memoria #(
  parameter int WIDTH_A     = 16,
  parameter int WIDTH_D     = 16,
  parameter int WAIT_CYCLES = 1
) (
  input logic               clock,
  input logic               reset_n,
  arbitro_memoria_if.slave  bus
);
  localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          gnt_if;
  logic          gnt_d;
  // last=1 means the data port was served most recently, so fetch wins the next tie
  always_comb begin
    gnt_if = !bus.halt && bus.req_if && (!bus.req_d || last);
    gnt_d  = !bus.halt && bus.req_d && !gnt_if;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      last          <= 1'b1;
      bus.ack_if    <= 1'b0;
      bus.ack_d     <= 1'b0;
      bus.rdata     <= '0;
      bus.busy      <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_if || gnt_d) begin
          state         <= ACCESS;
          cnt           <= CW'(WAIT_CYCLES);
          last          <= gnt_d;
          bus.busy      <= 1'b1;
          bus.mem_en    <= 1'b1;
          bus.mem_we    <= gnt_d && bus.we_d;
          bus.mem_addr  <= gnt_d ? bus.addr_d : bus.addr_if;
          bus.mem_wdata <= gnt_d ? bus.wdata_d : bus.mem_wdata;
        end
        ACCESS: if (cnt == '0) begin
          state      <= RESP;
          bus.rdata  <= bus.mem_rdata;
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          bus.ack_if <= !last;
          bus.ack_d  <= last;
        end else begin
          cnt <= cnt - CW'(1);
        end
        RESP: begin
          state      <= IDLE;
          bus.ack_if <= 1'b0;
          bus.ack_d  <= 1'b0;
          bus.busy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_arbitro_memoria.sv
// tb_arbitro_memoria: directed checks of arbiter timing, round-robin, halt and reset for W=1, W=3 and W=0
module tb_arbitro_memoria;
  logic clock = 1'b0;
  logic r1n, r3n, r0n;
  int   n_chk = 0;
  int   n_ok  = 0;
  always #5 clock = ~clock;
  arbitro_memoria_if #(.WIDTH_A(16), .WIDTH_D(16)) b1 ();
  arbitro_memoria_if #(.WIDTH_A(16), .WIDTH_D(16)) b3 ();
  arbitro_memoria_if #(.WIDTH_A(16), .WIDTH_D(16)) b0 ();
  arbitro_memoria #(.WIDTH_A(16), .WIDTH_D(16), .WAIT_CYCLES(1)) dut1 (.clock(clock), .reset_n(r1n), .bus(b1));
  arbitro_memoria #(.WIDTH_A(16), .WIDTH_D(16), .WAIT_CYCLES(3)) dut3 (.clock(clock), .reset_n(r3n), .bus(b3));
  arbitro_memoria #(.WIDTH_A(16), .WIDTH_D(16), .WAIT_CYCLES(0)) dut0 (.clock(clock), .reset_n(r0n), .bus(b0));
  function automatic logic [15:0] mem(input logic [15:0] a);
    return a == 16'h0010 ? 16'hA5C3 : a ^ 16'h5A5A;
  endfunction
  assign b1.mem_rdata = mem(b1.mem_addr);
  assign b3.mem_rdata = mem(b3.mem_addr);
  assign b0.mem_rdata = mem(b0.mem_addr);
  logic [4:0] s1, s3, s0;
  assign s1 = {b1.ack_if, b1.ack_d, b1.mem_en, b1.mem_we, b1.busy};
  assign s3 = {b3.ack_if, b3.ack_d, b3.mem_en, b3.mem_we, b3.busy};
  assign s0 = {b0.ack_if, b0.ack_d, b0.mem_en, b0.mem_we, b0.busy};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  initial begin
    int p;
    logic d;
    logic [4:0] e;
    r1n = 1'b0; r3n = 1'b0; r0n = 1'b0;
    b1.req_if = 1'b1; b1.req_d = 1'b1; b1.addr_if = 16'h0010; b1.addr_d = 16'h0200;
    b1.we_d = 1'b1; b1.wdata_d = 16'h1234; b1.halt = 1'b0;
    b3.req_if = 1'b0; b3.req_d = 1'b0; b3.addr_if = 16'h0000; b3.addr_d = 16'h0300;
    b3.we_d = 1'b1; b3.wdata_d = 16'hBEEF; b3.halt = 1'b0;
    b0.req_if = 1'b0; b0.req_d = 1'b0; b0.addr_if = 16'h0040; b0.addr_d = 16'h0000;
    b0.we_d = 1'b0; b0.wdata_d = 16'h0000; b0.halt = 1'b0;
    repeat (3) tick();
    check("rst_ctl", s1, 5'b00000);
    check("rst_bus", {b1.mem_addr, b1.mem_wdata}, 32'h0);
    check("rst_rdata", b1.rdata, 32'h0);
    check("rst_w3", s3, 5'b00000);
    check("rst_w0", s0, 5'b00000);
    // both ports held high: IF, D, IF, D, four cycles each (2 ACCESS, RESP, IDLE)
    r1n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      p = i % 4;
      d = ((i / 4) % 2) == 1;
      e = {p == 2 && !d, p == 2 && d, p < 2, p < 2 && d, p < 3};
      check($sformatf("cont%0d", i), s1, e);
      if (p < 2) check($sformatf("cont_addr%0d", i), b1.mem_addr, d ? 16'h0200 : 16'h0010);
      if (p < 2 && d) check($sformatf("cont_wdata%0d", i), b1.mem_wdata, 16'h1234);
      if (p == 2 && !d) check($sformatf("cont_rdata%0d", i), b1.rdata, 16'hA5C3);
    end
    tick();
    check("halt_grant", s1, 5'b00101);
    check("halt_addr", b1.mem_addr, 16'h0010);
    b1.halt = 1'b1;
    b1.req_if = 1'b0;
    tick();
    check("halt_acc", s1, 5'b00101);
    tick();
    check("halt_ack", s1, 5'b10001);
    tick();
    check("halt_idle", s1, 5'b00000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("halt_hold%0d", i), s1, 5'b00000);
    end
    b1.halt = 1'b0;
    tick();
    check("unhalt_grant", s1, 5'b00111);
    tick();
    check("unhalt_acc", s1, 5'b00111);
    tick();
    check("unhalt_ack", s1, 5'b01001);
    b1.req_d = 1'b0;
    tick();
    check("unhalt_idle", s1, 5'b00000);
    tick();
    check("no_regrant", s1, 5'b00000);
    // W=3 store aborted by reset in its second ACCESS cycle
    r3n = 1'b1;
    b3.req_d = 1'b1;
    tick();
    check("w3_grant", s3, 5'b00111);
    check("w3_bus", {b3.mem_addr, b3.mem_wdata}, 32'h0300BEEF);
    b3.req_d = 1'b0;
    tick();
    check("w3_acc2", s3, 5'b00111);
    r3n = 1'b0;
    tick();
    check("w3_abort", s3, 5'b00000);
    r3n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("w3_noack%0d", i), s3, 5'b00000);
    end
    // W=0: single ACCESS cycle, ack one cycle after the request edge
    r0n = 1'b1;
    b0.req_if = 1'b1;
    tick();
    check("w0_acc", s0, 5'b00101);
    check("w0_addr", b0.mem_addr, 16'h0040);
    tick();
    check("w0_ack", s0, 5'b10001);
    check("w0_rdata", b0.rdata, 16'h5A1A);
    b0.req_if = 1'b0;
    tick();
    check("w0_idle", s0, 5'b00000);
    tick();
    check("w0_hold", {s0, b0.rdata}, {5'b00000, 16'h5A1A});
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
